// File: rtl/upcount_mod10_ctrl.sv
// ---------------------------------------------------------------------------
// upcount_mod10_ctrl
//   Sequencing controller for a 4-bit BCD (mod-10) up-counter. A prescaler
//   inside the single I_CLK domain produces a clock-enable tick every I_DIV
//   cycles while running. The count runs 0..9 under start/stop/clear
//   commands, either wrapping continuously or stopping once at 9.
//
// Ports
//   I_CLK    in   system clock, rising edge
//   I_RSTN   in   asynchronous active-low reset
//   I_START  in   start (from IDLE/DONE) or resume (from PAUSE)
//   I_STOP   in   pause request, honoured in RUN only
//   I_CLR    in   synchronous clear to IDLE, highest priority
//   I_M      in   mode: 0 continuous wrap, 1 one-shot; latched on start
//   I_DIV    in   tick period in cycles (0 and 1 = every cycle); latched
//   O_Q      out  count value 0..9
//   O_TICK   out  one-cycle strobe when O_Q shows a newly incremented value
//   O_TC     out  one-cycle terminal-count strobe
//   O_STATE  out  IDLE=00 RUN=01 PAUSE=10 DONE=11
//   O_DONE   out  high while in DONE
// ---------------------------------------------------------------------------
module upcount_mod10_ctrl #(
    parameter int DIV_W = 26
) (
    input  logic             I_CLK,
    input  logic             I_RSTN,
    input  logic             I_START,
    input  logic             I_STOP,
    input  logic             I_CLR,
    input  logic             I_M,
    input  logic [DIV_W-1:0] I_DIV,
    output logic [3:0]       O_Q,
    output logic             O_TICK,
    output logic             O_TC,
    output logic [1:0]       O_STATE,
    output logic             O_DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] p_q, p_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic [3:0]       q_q, q_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] last_p;
    logic             tick_due;
    logic             start_new;
    logic             final_hit;

    // A divisor of 0 behaves like 1: the prescaler wraps at P == 0.
    assign last_p    = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    // The prescaler only runs in RUN; a tick due on the STOP cycle still lands.
    assign tick_due  = (state_q == RUN) && !I_CLR && (p_q == last_p);
    assign start_new = ((state_q == IDLE) || (state_q == DONE)) && I_START;
    assign final_hit = tick_due && mode_q && (q_q == 4'd8);

    // ---------------- state register ----------------
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (I_CLR) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (I_START) state_d = RUN;
                // Reaching 9 in one-shot finishes the run even if STOP
                // arrives on the same edge.
                RUN: begin
                    if (final_hit)   state_d = DONE;
                    else if (I_STOP) state_d = PAUSE;
                end
                PAUSE: if (I_START) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        p_d    = p_q;
        div_d  = div_q;
        mode_d = mode_q;
        q_d    = q_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (I_CLR) begin
            q_d = '0;
            p_d = '0;
        end else if (start_new) begin
            q_d    = '0;
            p_d    = '0;
            div_d  = I_DIV;
            mode_d = I_M;
        end else if (state_q == RUN) begin
            if (tick_due) begin
                p_d    = '0;
                tick_d = 1'b1;
                if (q_q >= 4'd9) begin
                    // continuous-mode wrap
                    q_d  = '0;
                    tc_d = 1'b1;
                end else begin
                    q_d  = q_q + 4'd1;
                    tc_d = mode_q && (q_q == 4'd8);
                end
            end else begin
                p_d = p_q + DIV_W'(1);
            end
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            p_q    <= '0;
            div_q  <= DIV_W'(1);
            mode_q <= 1'b0;
            q_q    <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            div_q  <= div_d;
            mode_q <= mode_d;
            q_q    <= q_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign O_Q     = q_q;
    assign O_TICK  = tick_q;
    assign O_TC    = tc_q;
    assign O_STATE = state_q;
    assign O_DONE  = done_q;

endmodule
